// File: rtl/sdram_click_tester_pkg.sv
// rtl/sdram_click_tester_pkg.sv - shared state encoding, error-count width and test-pattern helper
package sdram_click_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam int ERR_W = 8;

    // Word idx of the pattern: seed + idx, wrapped to the data width.
    function automatic logic [31:0] pattern_word(input logic [31:0] seed,
                                                 input logic [31:0] idx,
                                                 input int          width);
        logic [31:0] sum;
        sum = seed + idx;
        if (width < 32) begin
            sum = sum & ((32'd1 << width) - 32'd1);
        end
        return sum;
    endfunction

endpackage

// File: rtl/sdram_click_tester_rise_detect.sv
// rtl/sdram_click_tester_rise_detect.sv - registered copy of a level plus a rising-edge pulse
module sdram_click_tester_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic level_q;

    // Reset value 0 makes a level already high at reset release look like an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/sdram_click_tester.sv
// rtl/sdram_click_tester.sv - click-triggered SDRAM write-then-verify exerciser
module sdram_click_tester
    import sdram_click_tester_pkg::*;
#(
    parameter int                ADDR_W    = 24,
    parameter int                DATA_W    = 16,
    parameter int                NWORDS    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [31:0]       SEED      = 32'h0000_A5C3,
    parameter int                TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              single,
    input  logic              double,
    input  logic              busy,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              wr_enable,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_enable,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              tmo
);

    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);
    localparam logic [TW-1:0]    T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    logic single_rise;
    logic double_rise;

    sdram_click_tester_rise_detect u_single_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .level (single),
        .rise  (single_rise)
    );

    sdram_click_tester_rise_detect u_double_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .level (double),
        .rise  (double_rise)
    );

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [TW-1:0]     tcnt, tcnt_n;
    logic              combo, combo_n;
    logic              seen, seen_n;
    logic              wr_enable_n, rd_enable_n;
    logic [ADDR_W-1:0] wr_addr_n, rd_addr_n;
    logic [DATA_W-1:0] wr_data_n;
    logic              done_n, pass_n, fail_n, tmo_n;
    logic [ERR_W-1:0]  err_n, err_next;

    logic [DATA_W-1:0] exp_word;
    logic [ADDR_W-1:0] cur_addr;
    logic              last;

    assign exp_word = DATA_W'(pattern_word(SEED, 32'(idx), DATA_W));
    assign cur_addr = BASE_ADDR + ADDR_W'(idx);
    assign last     = (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            tcnt      <= '0;
            combo     <= 1'b0;
            seen      <= 1'b0;
            wr_enable <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_enable <= 1'b0;
            rd_addr   <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            err_cnt   <= '0;
            tmo       <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            tcnt      <= tcnt_n;
            combo     <= combo_n;
            seen      <= seen_n;
            wr_enable <= wr_enable_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
            rd_enable <= rd_enable_n;
            rd_addr   <= rd_addr_n;
            done      <= done_n;
            pass      <= pass_n;
            fail      <= fail_n;
            err_cnt   <= err_n;
            tmo       <= tmo_n;
        end
    end

    // Result flags are set on the transition into DONE so done/pass/fail/tmo move together.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        tcnt_n      = tcnt;
        combo_n     = combo;
        seen_n      = seen;
        wr_enable_n = 1'b0;
        rd_enable_n = 1'b0;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        rd_addr_n   = rd_addr;
        done_n      = done;
        pass_n      = pass;
        fail_n      = fail;
        tmo_n       = tmo;
        err_n       = err_cnt;
        err_next    = err_cnt;

        case (state)
            ST_IDLE: begin
                if (single_rise || double_rise) begin
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                    fail_n  = 1'b0;
                    tmo_n   = 1'b0;
                    err_n   = '0;
                    idx_n   = '0;
                    combo_n = single_rise & double_rise;
                    state_n = single_rise ? ST_WR_REQ : ST_RD_REQ;
                end
            end

            ST_WR_REQ: begin
                if (!busy) begin
                    wr_enable_n = 1'b1;
                    wr_addr_n   = cur_addr;
                    wr_data_n   = exp_word;
                    tcnt_n      = '0;
                    seen_n      = 1'b0;
                    state_n     = ST_WR_WAIT;
                end
            end

            ST_WR_WAIT: begin
                tcnt_n = tcnt + 1'b1;
                if (seen && !busy) begin
                    if (!last) begin
                        idx_n   = idx + 1'b1;
                        state_n = ST_WR_REQ;
                    end else if (combo) begin
                        idx_n   = '0;
                        combo_n = 1'b0;
                        state_n = ST_RD_REQ;
                    end else begin
                        done_n  = 1'b1;
                        pass_n  = 1'b0;
                        fail_n  = 1'b0;
                        state_n = ST_DONE;
                    end
                end else if (tcnt == T_LAST) begin
                    tmo_n   = 1'b1;
                    fail_n  = 1'b1;
                    pass_n  = 1'b0;
                    done_n  = 1'b1;
                    combo_n = 1'b0;
                    state_n = ST_DONE;
                end else if (busy) begin
                    seen_n = 1'b1;
                end
            end

            ST_RD_REQ: begin
                if (!busy) begin
                    rd_enable_n = 1'b1;
                    rd_addr_n   = cur_addr;
                    tcnt_n      = '0;
                    state_n     = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                tcnt_n = tcnt + 1'b1;
                if (rd_ready) begin
                    if (rd_data != exp_word && err_cnt != ERR_MAX) begin
                        err_next = err_cnt + 1'b1;
                    end
                    err_n = err_next;
                    if (!last) begin
                        idx_n   = idx + 1'b1;
                        state_n = ST_RD_REQ;
                    end else begin
                        done_n  = 1'b1;
                        pass_n  = (err_next == '0);
                        fail_n  = (err_next != '0);
                        state_n = ST_DONE;
                    end
                end else if (tcnt == T_LAST) begin
                    tmo_n   = 1'b1;
                    fail_n  = 1'b1;
                    pass_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = ST_DONE;
                end
            end

            ST_DONE: begin
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_click_tester.sv
// tb/tb_sdram_click_tester.sv - randomized self-checking bench with a controller/memory model
module tb_sdram_click_tester;

    localparam int          ADDR_W  = 24;
    localparam int          DATA_W  = 16;
    localparam int          NWORDS  = 16;
    localparam int          TIMEOUT = 1023;
    localparam logic [15:0] SEED_M  = 16'hA5C3;

    logic              clk;
    logic              rst_n;
    logic              single;
    logic              double;
    logic              busy;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
    logic              wr_enable;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_enable;
    logic [ADDR_W-1:0] rd_addr;
    logic              done;
    logic              pass;
    logic              fail;
    logic [7:0]        err_cnt;
    logic              tmo;

    sdram_click_tester #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NWORDS    (NWORDS),
        .BASE_ADDR (24'd0),
        .SEED      (32'h0000_A5C3),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .single    (single),
        .double    (double),
        .busy      (busy),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .wr_enable (wr_enable),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_enable (rd_enable),
        .rd_addr   (rd_addr),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .err_cnt   (err_cnt),
        .tmo       (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [15:0] model_word(input int i);
        return 16'(SEED_M + 16'(i));
    endfunction

    function automatic logic [23:0] model_addr(input int i);
        return 24'(i);
    endfunction

    // Controller model: busy for 2 cycles per accepted request, read data 3 cycles later.
    logic [15:0] mem [0:255];
    logic [15:0] corrupt_mask = '0;
    logic        dead = 1'b0;
    int          fill_mode = 0;
    int          bcnt = 0;
    int          rcnt = 0;
    logic [7:0]  raddr = '0;

    assign busy = (bcnt != 0);

    always @(posedge clk) begin
        if (fill_mode == 1) begin
            for (int a = 0; a < 256; a++) mem[a] <= model_word(a);
        end else if (fill_mode == 2) begin
            for (int a = 0; a < 256; a++) mem[a] <= 16'($urandom);
        end
        if (!rst_n) begin
            bcnt     <= 0;
            rcnt     <= 0;
            rd_ready <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_ready <= 1'b0;
            if (bcnt != 0) bcnt <= bcnt - 1;
            if (rcnt != 0) begin
                rcnt <= rcnt - 1;
                if (rcnt == 1) begin
                    rd_ready <= 1'b1;
                    rd_data  <= mem[raddr] ^ (corrupt_mask[raddr[3:0]] ? 16'h0100 : 16'h0000);
                end
            end
            if (!dead && wr_enable) begin
                mem[wr_addr[7:0]] <= wr_data;
                bcnt <= 2;
            end
            if (!dead && rd_enable) begin
                raddr <= rd_addr[7:0];
                rcnt  <= 3;
                bcnt  <= 2;
            end
        end
    end

    typedef struct {
        logic        is_rd;
        logic [23:0] addr;
        logic [15:0] data;
        int          cyc;
    } ev_t;

    ev_t  evq[$];
    int   cyc = 0;
    int   done_rises = 0;
    int   done_cyc = 0;
    int   wide_viol = 0;
    logic prev_wr = 1'b0;
    logic prev_rd = 1'b0;
    logic prev_done = 1'b0;

    always @(posedge clk) begin
        cyc++;
        #2;
        if (wr_enable) evq.push_back('{is_rd: 1'b0, addr: wr_addr, data: wr_data, cyc: cyc});
        if (rd_enable) evq.push_back('{is_rd: 1'b1, addr: rd_addr, data: 16'h0, cyc: cyc});
        if ((wr_enable && prev_wr) || (rd_enable && prev_rd) || (wr_enable && rd_enable)
            || ((wr_enable || rd_enable) && busy)) wide_viol++;
        if (done && !prev_done) begin
            done_rises++;
            done_cyc = cyc;
        end
        prev_wr   = wr_enable;
        prev_rd   = rd_enable;
        prev_done = done;
    end

    task automatic clear_logs();
        evq.delete();
        done_rises = 0;
        wide_viol  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        single = 1'b0;
        double = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic fill_mem(input int mode);
        @(negedge clk);
        fill_mode = mode;
        @(negedge clk);
        fill_mode = 0;
    endtask

    task automatic wait_done(input int budget, output logic ok);
        int n;
        n = 0;
        while (done_rises == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        ok = (done_rises != 0);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if ({wr_enable, wr_addr, wr_data, rd_enable, rd_addr, done, pass, fail, err_cnt, tmo} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got we=%b wa=%h wd=%h re=%b ra=%h done=%b pass=%b fail=%b err=%0d tmo=%b, want all 0",
                     wr_enable, wr_addr, wr_data, rd_enable, rd_addr, done, pass, fail, err_cnt, tmo);
        end
    endtask

    task automatic test_write_phase();
        logic ok;
        clear_logs();
        repeat ($urandom_range(1, 6)) @(negedge clk);
        single = 1'b1;
        wait_done(2000, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL write_done_seen: got 0 want 1"); end
        n_cmp++;
        if (evq.size() != NWORDS) begin
            n_bad++;
            $display("FAIL write_count: got %0d want %0d", evq.size(), NWORDS);
        end else begin
            for (int i = 0; i < NWORDS; i++) begin
                n_cmp++;
                if (evq[i].is_rd !== 1'b0 || evq[i].addr !== model_addr(i) || evq[i].data !== model_word(i)) begin
                    n_bad++;
                    $display("FAIL write_word%0d: got rd=%b addr=%h data=%h want rd=0 addr=%h data=%h",
                             i, evq[i].is_rd, evq[i].addr, evq[i].data, model_addr(i), model_word(i));
                end
            end
        end
        n_cmp++;
        if ({done, pass, fail, tmo, err_cnt} !== {4'b1000, 8'd0}) begin
            n_bad++;
            $display("FAIL write_status: got done=%b pass=%b fail=%b tmo=%b err=%0d want 1 0 0 0 0",
                     done, pass, fail, tmo, err_cnt);
        end
        n_cmp++;
        if (wide_viol != 0) begin
            n_bad++;
            $display("FAIL write_req_shape: got %0d violations want 0", wide_viol);
        end
    endtask

    task automatic test_read_pass();
        logic ok;
        clear_logs();
        repeat ($urandom_range(1, 6)) @(negedge clk);
        double = 1'b1;
        wait_done(2000, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL read_done_seen: got 0 want 1"); end
        n_cmp++;
        if (evq.size() != NWORDS) begin
            n_bad++;
            $display("FAIL read_count: got %0d want %0d", evq.size(), NWORDS);
        end else begin
            for (int i = 0; i < NWORDS; i++) begin
                n_cmp++;
                if (evq[i].is_rd !== 1'b1 || evq[i].addr !== model_addr(i)) begin
                    n_bad++;
                    $display("FAIL read_addr%0d: got rd=%b addr=%h want rd=1 addr=%h",
                             i, evq[i].is_rd, evq[i].addr, model_addr(i));
                end
            end
        end
        n_cmp++;
        if ({done, pass, fail, tmo, err_cnt} !== {4'b1100, 8'd0}) begin
            n_bad++;
            $display("FAIL read_pass_status: got done=%b pass=%b fail=%b tmo=%b err=%0d want 1 1 0 0 0",
                     done, pass, fail, tmo, err_cnt);
        end
    endtask

    task automatic test_read_corrupt(input logic [15:0] mask, input string name);
        logic ok;
        int   exp_err;
        do_reset();
        fill_mem(1);
        corrupt_mask = mask;
        exp_err = 0;
        for (int i = 0; i < NWORDS; i++) if (mask[i]) exp_err++;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        double = 1'b1;
        wait_done(2000, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL %s_done_seen: got 0 want 1", name); end
        n_cmp++;
        if (evq.size() != NWORDS) begin
            n_bad++;
            $display("FAIL %s_count: got %0d want %0d", name, evq.size(), NWORDS);
        end
        n_cmp++;
        if (err_cnt !== 8'(exp_err) || pass !== (exp_err == 0) || fail !== (exp_err != 0) || done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_status: got err=%0d pass=%b fail=%b done=%b want err=%0d pass=%b fail=%b done=1",
                     name, err_cnt, pass, fail, done, exp_err, exp_err == 0, exp_err != 0);
        end
        corrupt_mask = '0;
    endtask

    task automatic test_ignored_edge();
        logic ok;
        do_reset();
        single = 1'b1;
        repeat (15) @(negedge clk);
        double = 1'b1;
        wait_done(2000, ok);
        repeat (50) @(negedge clk);
        n_cmp++;
        if (ok !== 1'b1 || evq.size() != NWORDS || evq[NWORDS-1].is_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL ignored_edge_reqs: got done_seen=%b reqs=%0d want 1 and %0d writes only",
                     ok, evq.size(), NWORDS);
        end
        n_cmp++;
        if ({done, pass, fail} !== 3'b100) begin
            n_bad++;
            $display("FAIL ignored_edge_status: got done=%b pass=%b fail=%b want 1 0 0", done, pass, fail);
        end
    endtask

    task automatic test_back_to_back();
        logic ok;
        do_reset();
        fill_mem(2);
        repeat ($urandom_range(1, 6)) @(negedge clk);
        single = 1'b1;
        double = 1'b1;
        wait_done(4000, ok);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (evq.size() != 2 * NWORDS) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d want %0d", evq.size(), 2 * NWORDS);
        end else begin
            for (int i = 0; i < 2 * NWORDS; i++) begin
                n_cmp++;
                if (evq[i].is_rd !== (i >= NWORDS) || evq[i].addr !== model_addr(i % NWORDS)) begin
                    n_bad++;
                    $display("FAIL b2b_req%0d: got rd=%b addr=%h want rd=%b addr=%h",
                             i, evq[i].is_rd, evq[i].addr, i >= NWORDS, model_addr(i % NWORDS));
                end
            end
        end
        n_cmp++;
        if (done_rises != 1) begin
            n_bad++;
            $display("FAIL b2b_done_count: got %0d want 1", done_rises);
        end
        n_cmp++;
        if ({done, pass, fail, err_cnt} !== {3'b110, 8'd0}) begin
            n_bad++;
            $display("FAIL b2b_status: got done=%b pass=%b fail=%b err=%0d want 1 1 0 0", done, pass, fail, err_cnt);
        end
    endtask

    task automatic test_timeout();
        logic ok;
        do_reset();
        dead = 1'b1;
        single = 1'b1;
        wait_done(3000, ok);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (ok !== 1'b1 || evq.size() != 1) begin
            n_bad++;
            $display("FAIL timeout_reqs: got done_seen=%b reqs=%0d want 1 and 1", ok, evq.size());
        end else begin
            n_cmp++;
            if (done_cyc - evq[0].cyc != TIMEOUT) begin
                n_bad++;
                $display("FAIL timeout_latency: got %0d cycles want %0d", done_cyc - evq[0].cyc, TIMEOUT);
            end
        end
        n_cmp++;
        if ({done, pass, fail, tmo} !== 4'b1011) begin
            n_bad++;
            $display("FAIL timeout_status: got done=%b pass=%b fail=%b tmo=%b want 1 0 1 1", done, pass, fail, tmo);
        end
        dead = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic ok;
        int   n;
        do_reset();
        single = 1'b1;
        n = 0;
        while (evq.size() < 8 && n < 500) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (evq.size() < 8) begin
            n_bad++;
            $display("FAIL midreset_reach_word7: got %0d reqs want 8", evq.size());
        end
        rst_n  = 1'b0;
        single = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wr_enable, wr_addr, wr_data, rd_enable, rd_addr, done, pass, fail, err_cnt, tmo} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got we=%b wa=%h wd=%h re=%b ra=%h done=%b err=%0d want all 0",
                     wr_enable, wr_addr, wr_data, rd_enable, rd_addr, done, err_cnt);
        end
        rst_n = 1'b1;
        clear_logs();
        repeat (10) @(negedge clk);
        n_cmp++;
        if (evq.size() != 0) begin
            n_bad++;
            $display("FAIL midreset_quiet: got %0d reqs want 0", evq.size());
        end
        single = 1'b1;
        wait_done(2000, ok);
        n_cmp++;
        if (ok !== 1'b1 || evq.size() != NWORDS || evq[0].addr !== 24'd0 || evq[NWORDS-1].addr !== model_addr(NWORDS - 1)
            || evq[NWORDS-1].data !== model_word(NWORDS - 1)) begin
            n_bad++;
            $display("FAIL midreset_restart: got done_seen=%b reqs=%0d want 1 and %0d writes from addr 0",
                     ok, evq.size(), NWORDS);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        single = 1'b0;
        double = 1'b0;
        test_reset();
        test_write_phase();
        test_read_pass();
        test_read_corrupt(16'h0220, "corrupt_5_9");
        for (int k = 0; k < 3; k++) test_read_corrupt(16'($urandom), "corrupt_rand");
        test_read_corrupt(16'h0000, "corrupt_none");
        test_ignored_edge();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
